// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector result drain.
//   N_NODES_DEF / RES_W_DEF / OUT_W_DEF : default geometry of one result row
//   drain_state_t                       : output stream FSM encoding
//   sign_extend()                       : widens a RES-bit two's complement value
package mv_pkg;

  localparam int N_NODES_DEF = 8;
  localparam int RES_W_DEF   = 25;
  localparam int OUT_W_DEF   = 32;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } drain_state_t;

  // Sign-extends the low res_w bits of val to 64 bits. res_w is a
  // constant at every call site, so this collapses to plain wiring.
  function automatic logic [63:0] sign_extend(input logic [63:0] val,
                                              input int          res_w);
    logic [63:0] ext;
    logic [5:0]  sign_bit;
    sign_bit = 6'(res_w - 1);
    for (int i = 0; i < 64; i++) begin
      ext[i] = (i < res_w) ? val[i] : val[sign_bit];
    end
    return ext;
  endfunction

endpackage

// File: rtl/mv_drain_bank.sv
// Two-bank ping-pong store for one row of node results.
//   clk     : system clock
//   i_we    : write the whole row into bank i_wsel this edge
//   i_wsel  : bank selected for writing
//   i_wdata : full row, node k in bits [k*RES_W +: RES_W]
//   i_rsel  : bank selected for reading
//   i_ridx  : node index to read
//   o_rdata : combinational read of node i_ridx from bank i_rsel
// Contents are not reset; the controller never reads a bank it has not filled.
module mv_drain_bank
  import mv_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int IDX_W   = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic                     i_wsel,
  input  logic [N_NODES*RES_W-1:0] i_wdata,
  input  logic                     i_rsel,
  input  logic [IDX_W-1:0]         i_ridx,
  output logic [RES_W-1:0]         o_rdata
);

  logic [N_NODES*RES_W-1:0] r_mem [2];
  logic [N_NODES*RES_W-1:0] w_row;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wsel] <= i_wdata;
    end
  end

  assign w_row   = r_mem[i_rsel];
  assign o_rdata = w_row[i_ridx*RES_W +: RES_W];

endmodule

// File: rtl/mv_result_drain.sv
// Captures a full row of node results on a completion strobe, buffers up to
// two rows in a ping-pong store and streams them out one sign-extended word
// per cycle.
//   clk, rstn          : clock, synchronous active-low reset
//   cap_valid/cap_data : one-cycle capture strobe with the whole row
//   cap_ready          : a bank is free, a strobe this cycle is accepted
//   m_tdata/m_tvalid/m_tready/m_tlast : output word stream, tlast on node N-1
//   ovf, ovf_clr       : sticky dropped-capture flag and its clear
//   busy               : at least one bank still holds undrained data
//   o_dbg_state        : current output FSM state
//
// Stream handshake: a word transfers on a rising edge where m_tvalid and
// m_tready are both high. Once m_tvalid is raised, m_tvalid, m_tdata and
// m_tlast stay unchanged until that transfer happens; m_tvalid never depends
// combinationally on m_tready.
module mv_result_drain
  import mv_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cap_valid,
  input  logic [N_NODES*RES_W-1:0] cap_data,
  output logic                     cap_ready,
  output logic [OUT_W-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     busy,
  output drain_state_t             o_dbg_state
);

  localparam int               IDX_W    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NODES - 1);

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_count;
  logic [1:0]       w_count_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovf;

  logic             w_cap;
  logic             w_drop;
  logic             w_tvalid;
  logic             w_last;
  logic             w_hs;
  logic             w_row_done;
  logic [RES_W-1:0] w_res;

  assign cap_ready  = (r_count != 2'd2);
  assign w_cap      = cap_valid & cap_ready;
  assign w_drop     = cap_valid & ~cap_ready;
  // The stream is valid exactly while a filled bank exists, so the first
  // word appears the cycle after its capture edge.
  assign w_tvalid   = (r_state == S_STREAM);
  assign w_last     = w_tvalid & (r_idx == LAST_IDX);
  assign w_hs       = w_tvalid & m_tready;
  assign w_row_done = w_hs & w_last;

  mv_drain_bank #(
    .N_NODES (N_NODES),
    .RES_W   (RES_W),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_cap),
    .i_wsel  (r_wr_bank),
    .i_wdata (cap_data),
    .i_rsel  (r_rd_bank),
    .i_ridx  (r_idx),
    .o_rdata (w_res)
  );

  // Capture and row completion on the same edge cancel out in the count.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_cap, w_row_done})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_count_nxt != 2'd0) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        // Staying in STREAM when the other bank is full gives a bubble-free
        // switch to word 0 of the next row.
        if (w_row_done && (w_count_nxt == 2'd0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_count   <= 2'd0;
      r_idx     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_cap) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_hs) begin
        if (w_last) begin
          r_idx     <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      // A new drop outranks a simultaneous clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign m_tvalid    = w_tvalid;
  assign m_tlast     = w_last;
  assign m_tdata     = w_tvalid ? OUT_W'(sign_extend(64'(w_res), RES_W)) : '0;
  assign ovf         = r_ovf;
  assign busy        = (r_count != 2'd0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mv_result_drain.sv
// Bench for mv_result_drain: directed scenarios plus a random phase, all
// checked against a row/word queue model of the drain.
module tb_mv_result_drain;
  import mv_pkg::*;

  localparam int N  = N_NODES_DEF;
  localparam int RW = RES_W_DEF;
  localparam int OW = OUT_W_DEF;
  localparam int EW = OW + 1;   // {tlast, word}

  // ---------------- clock / reset ----------------
  logic              clk       = 1'b0;
  logic              rstn      = 1'b0;
  logic              cap_valid = 1'b0;
  logic [N*RW-1:0]   cap_data  = '0;
  logic              m_tready  = 1'b0;
  logic              ovf_clr   = 1'b0;
  logic              cap_ready;
  logic [OW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              ovf;
  logic              busy;
  drain_state_t      dbg_state;

  always #5 clk = ~clk;

  mv_result_drain #(
    .N_NODES (N),
    .RES_W   (RW),
    .OUT_W   (OW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cap_valid   (cap_valid),
    .cap_data    (cap_data),
    .cap_ready   (cap_ready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];
  int            rows_pending = 0;
  bit            ovf_m        = 1'b0;
  int            n_checks     = 0;
  int            n_errors     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Two's complement value of the result, rewritten as an OW-bit word.
  function automatic logic [OW-1:0] ext_word(input logic [RW-1:0] r);
    longint v;
    v = longint'(r);
    if (v >= (longint'(1) << (RW - 1))) v = v - (longint'(1) << RW);
    return OW'(v);
  endfunction

  task automatic push_row(input logic [N*RW-1:0] d);
    logic [RW-1:0] r;
    for (int k = 0; k < N; k++) begin
      r = d[k*RW +: RW];
      exp_q.push_back({(k == N - 1) ? 1'b1 : 1'b0, ext_word(r)});
    end
    rows_pending++;
  endtask

  function automatic logic [N*RW-1:0] rand_row();
    logic [N*RW-1:0] d;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 5))
        0:       d[k*RW +: RW] = '1;
        1:       d[k*RW +: RW] = {1'b1, {(RW-1){1'b0}}};
        2:       d[k*RW +: RW] = {1'b0, {(RW-1){1'b1}}};
        default: d[k*RW +: RW] = RW'($urandom);
      endcase
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  // One clock: drive at the falling edge, check settled outputs against the
  // model, then advance the model by what the coming rising edge does.
  task automatic cycle(input bit v, input logic [N*RW-1:0] d, input bit rdy,
                       input bit clr, input bit rst_n);
    logic [EW-1:0] head;
    bit            exp_valid;
    bit            accept;
    @(negedge clk);
    cap_valid = v;
    cap_data  = d;
    m_tready  = rdy;
    ovf_clr   = clr;
    rstn      = rst_n;
    #1;
    exp_valid = (exp_q.size() != 0);
    check("cap_ready", cap_ready, rows_pending != 2);
    check("busy", busy, rows_pending != 0);
    check("ovf", ovf, ovf_m);
    check("tvalid", m_tvalid, exp_valid);
    if (exp_valid) begin
      head = exp_q[0];
      check("tdata", m_tdata, head[OW-1:0]);
      check("tlast", m_tlast, head[OW]);
    end
    if (!rst_n) begin
      exp_q.delete();
      rows_pending = 0;
      ovf_m        = 1'b0;
    end else begin
      accept = v && (rows_pending != 2);
      if (exp_valid && rdy) begin
        head = exp_q.pop_front();
        if (head[OW]) rows_pending--;
      end
      if (accept) push_row(d);
      if (v && !accept) ovf_m = 1'b1;
      else if (clr)     ovf_m = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0, 1'b1);
  endtask

  // Advance with tready=1 until the last word of a row is at the head while
  // `target` rows are buffered.
  task automatic wait_last(input int target);
    int guard;
    guard = 0;
    while (!(exp_q.size() != 0 && exp_q[0][OW] && rows_pending == target) && guard < 40) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      guard++;
    end
    check("wait_last_bound", guard < 40, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N*RW-1:0] row;

    // reset
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rst_tdata", m_tdata, '0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_state", dbg_state, S_IDLE);

    // single row, node k = 3k, node 2 = all ones
    for (int k = 0; k < N; k++) row[k*RW +: RW] = RW'(k * 3);
    row[2*RW +: RW] = '1;
    cycle(1'b1, row, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);

    // backpressure 1,0,0,1
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      cycle(1'b0, '0, ((i % 4) == 0) || ((i % 4) == 3), 1'b0, 1'b1);

    // ping-pong, captures two cycles apart
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(20, 1'b1);

    // overflow: three captures with the consumer stalled
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, rand_row(), 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0);
    end
    idle(20, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // capture on the final-word handshake with one row buffered
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    wait_last(1);
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(20, 1'b1);

    // same with both banks full: refused, ovf set (left set for the reset test)
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    wait_last(2);
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // reset while word 4 is presented
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);
    cycle(1'b1, rand_row(), 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 5) == 0, rand_row(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 30) == 0, 1'b1);
    idle(40, 1'b1);
    check("drained_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
